// File: rtl/samplerenctrl_pkg.sv
// -----------------------------------------------------------------------------
// samplerenctrl_pkg
// Shared definitions for the sampler enable controller.
//   - Default widths for the divider, the burst/sample counter and warm-up.
//   - 2-bit state encoding used by the controller FSM and its debug output.
// -----------------------------------------------------------------------------
package samplerenctrl_pkg;

    localparam int DEF_DIV_W = 8;
    localparam int DEF_CNT_W = 16;
    localparam int DEF_WUP_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_RUN    = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // busy is reported whenever a run is actively in progress.
    function automatic logic is_busy_state(input state_e s);
        return (s == ST_WARMUP) || (s == ST_RUN);
    endfunction

endpackage

// File: rtl/samplerenctrl_divider.sv
// -----------------------------------------------------------------------------
// samplerenctrl_divider
// Clearable modulo counter with a terminal-count tick. Used both as the
// sample-period divider and as the warm-up timer.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear of the count (takes priority over en)
//   en         : count enable
//   term       : terminal count; the counter wraps to 0 after reaching it
//   tick       : high in the cycle the enabled counter equals term
// -----------------------------------------------------------------------------
module samplerenctrl_divider #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] term,
    output logic         tick
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic         at_term;

    assign at_term = (cnt_q == term);
    assign tick    = en && !clr && at_term;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = at_term ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/samplerenctrl.sv
// -----------------------------------------------------------------------------
// samplerenctrl
// Sampler-domain run controller. A rising edge of the synchronized enable
// starts a run: optional warm-up, then paced sample requests (req/ack) until
// the programmed burst length is reached (or forever when it is 0).
// Ports:
//   clk_sampler, rst_sampler_n_sync           : clock, async active-low reset
//   clksamplerensync_..._clksampleren_r_sync  : enable level (en)
//   samplertop_samplerenctrl_div              : sample period minus 1
//   samplertop_samplerenctrl_nsamples         : burst length, 0 = continuous
//   samplertop_samplerenctrl_warmup           : warm-up cycles before RUN
//   sampler_samplerenctrl_ack                 : single-cycle ack of req
//   samplerenctrl_sampler_req                 : sample request level
//   samplerenctrl_samplertop_busy/done        : run status
//   samplerenctrl_samplertop_overrun          : sticky dropped-tick flag
//   samplerenctrl_samplertop_cnt              : samples issued this run
//   samplerenctrl_dbg_state                   : current FSM state (debug)
// Handshake: req is a level held from the clock after an accepted tick until
// the clock after a cycle in which ack is sampled high; ack while req is low
// is ignored. An ack coinciding with a new tick keeps req high and counts as
// both the completion of the old request and the start of a new one.
// All outputs are registered.
// -----------------------------------------------------------------------------
module samplerenctrl
    import samplerenctrl_pkg::*;
#(
    parameter int DIV_W = DEF_DIV_W,
    parameter int CNT_W = DEF_CNT_W,
    parameter int WUP_W = DEF_WUP_W
) (
    input  logic             clk_sampler,
    input  logic             rst_sampler_n_sync,
    input  logic             clksamplerensync_samplerenctrl_clksampleren_r_sync,
    input  logic [DIV_W-1:0] samplertop_samplerenctrl_div,
    input  logic [CNT_W-1:0] samplertop_samplerenctrl_nsamples,
    input  logic [WUP_W-1:0] samplertop_samplerenctrl_warmup,
    input  logic             sampler_samplerenctrl_ack,
    output logic             samplerenctrl_sampler_req,
    output logic             samplerenctrl_samplertop_busy,
    output logic             samplerenctrl_samplertop_done,
    output logic             samplerenctrl_samplertop_overrun,
    output logic [CNT_W-1:0] samplerenctrl_samplertop_cnt,
    output state_e           samplerenctrl_dbg_state
);

    logic en;
    logic ack;

    assign en  = clksamplerensync_samplerenctrl_clksampleren_r_sync;
    assign ack = sampler_samplerenctrl_ack;

    state_e           state_q,   state_d;
    logic             en_q,      en_d;
    logic             req_q,     req_d;
    logic             busy_q,    busy_d;
    logic             done_q,    done_d;
    logic             overrun_q, overrun_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [DIV_W-1:0] div_sh_q,  div_sh_d;
    logic [CNT_W-1:0] ns_sh_q,   ns_sh_d;
    logic [WUP_W-1:0] wup_sh_q,  wup_sh_d;

    logic start;
    logic full;
    logic wup_tick;
    logic run_tick;

    // A run starts only on a 0->1 transition of en.
    assign start = en && !en_q;

    // Burst reached: further ticks are suppressed without flagging overrun.
    assign full = (ns_sh_q != '0) && (cnt_q == ns_sh_q);

    // Warm-up timer: held at 0 outside WARMUP, terminal count warmup-1 so
    // WARMUP lasts exactly warmup cycles (never entered with warmup = 0).
    samplerenctrl_divider #(
        .W (WUP_W)
    ) u_wup_timer (
        .clk   (clk_sampler),
        .rst_n (rst_sampler_n_sync),
        .clr   (state_q != ST_WARMUP),
        .en    (state_q == ST_WARMUP),
        .term  (wup_sh_q - WUP_W'(1)),
        .tick  (wup_tick)
    );

    // Sample-period divider: held at 0 outside RUN so it starts from 0 on
    // RUN entry; first tick lands on RUN cycle index div_sh.
    samplerenctrl_divider #(
        .W (DIV_W)
    ) u_div (
        .clk   (clk_sampler),
        .rst_n (rst_sampler_n_sync),
        .clr   (state_q != ST_RUN),
        .en    (state_q == ST_RUN),
        .term  (div_sh_q),
        .tick  (run_tick)
    );

    always_comb begin
        state_d   = state_q;
        en_d      = en;
        req_d     = req_q;
        cnt_d     = cnt_q;
        overrun_d = overrun_q;
        div_sh_d  = div_sh_q;
        ns_sh_d   = ns_sh_q;
        wup_sh_d  = wup_sh_q;

        case (state_q)
            ST_IDLE: begin
                req_d = 1'b0;
                if (start) begin
                    div_sh_d  = samplertop_samplerenctrl_div;
                    ns_sh_d   = samplertop_samplerenctrl_nsamples;
                    wup_sh_d  = samplertop_samplerenctrl_warmup;
                    cnt_d     = '0;
                    overrun_d = 1'b0;
                    state_d   = (samplertop_samplerenctrl_warmup == '0) ? ST_RUN : ST_WARMUP;
                end
            end

            ST_WARMUP: begin
                if (!en) begin
                    state_d = ST_IDLE;
                end else if (wup_tick) begin
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                if (!en) begin
                    // Abort beats a coincident tick; outstanding req is dropped.
                    state_d = ST_IDLE;
                    req_d   = 1'b0;
                end else if (full) begin
                    if (!req_q) begin
                        state_d = ST_DONE;
                    end else if (ack) begin
                        req_d = 1'b0;
                    end
                end else if (run_tick) begin
                    if (!req_q || ack) begin
                        req_d = 1'b1;
                        if (cnt_q != {CNT_W{1'b1}}) begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else begin
                        overrun_d = 1'b1;
                    end
                end else if (ack) begin
                    req_d = 1'b0;
                end
            end

            ST_DONE: begin
                req_d = 1'b0;
                if (!en) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase

        busy_d = is_busy_state(state_d);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk_sampler or negedge rst_sampler_n_sync) begin
        if (!rst_sampler_n_sync) begin
            state_q   <= ST_IDLE;
            en_q      <= 1'b0;
            req_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            cnt_q     <= '0;
            div_sh_q  <= '0;
            ns_sh_q   <= '0;
            wup_sh_q  <= '0;
        end else begin
            state_q   <= state_d;
            en_q      <= en_d;
            req_q     <= req_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
            cnt_q     <= cnt_d;
            div_sh_q  <= div_sh_d;
            ns_sh_q   <= ns_sh_d;
            wup_sh_q  <= wup_sh_d;
        end
    end

    assign samplerenctrl_sampler_req        = req_q;
    assign samplerenctrl_samplertop_busy    = busy_q;
    assign samplerenctrl_samplertop_done    = done_q;
    assign samplerenctrl_samplertop_overrun = overrun_q;
    assign samplerenctrl_samplertop_cnt     = cnt_q;
    assign samplerenctrl_dbg_state          = state_q;

endmodule

// File: tb/tb_samplerenctrl.sv
// -----------------------------------------------------------------------------
// tb_samplerenctrl
// Directed scenarios followed by a randomized run, every cycle compared
// against a run-level reference model (phase + cycle age, tick by modulo).
// -----------------------------------------------------------------------------
module tb_samplerenctrl;
    import samplerenctrl_pkg::*;

    localparam int DIV_W = 8;
    localparam int CNT_W = 16;
    localparam int WUP_W = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic             en  = 1'b0;
    logic [DIV_W-1:0] div = '0;
    logic [CNT_W-1:0] ns  = '0;
    logic [WUP_W-1:0] wup = '0;
    logic             ack = 1'b0;
    logic             req_o;
    logic             busy_o;
    logic             done_o;
    logic             ovr_o;
    logic [CNT_W-1:0] cnt_o;
    state_e           dbg_o;

    samplerenctrl #(
        .DIV_W (DIV_W),
        .CNT_W (CNT_W),
        .WUP_W (WUP_W)
    ) dut (
        .clk_sampler                                        (clk),
        .rst_sampler_n_sync                                 (rst_n),
        .clksamplerensync_samplerenctrl_clksampleren_r_sync (en),
        .samplertop_samplerenctrl_div                       (div),
        .samplertop_samplerenctrl_nsamples                  (ns),
        .samplertop_samplerenctrl_warmup                    (wup),
        .sampler_samplerenctrl_ack                          (ack),
        .samplerenctrl_sampler_req                          (req_o),
        .samplerenctrl_samplertop_busy                      (busy_o),
        .samplerenctrl_samplertop_done                      (done_o),
        .samplerenctrl_samplertop_overrun                   (ovr_o),
        .samplerenctrl_samplertop_cnt                       (cnt_o),
        .samplerenctrl_dbg_state                            (dbg_o)
    );

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    localparam int P_IDLE = 0;
    localparam int P_WUP  = 1;
    localparam int P_RUN  = 2;
    localparam int P_DONE = 3;

    int m_phase, m_age, m_div, m_ns, m_wup, m_cnt;
    bit m_en_q, m_req, m_ovr;

    task automatic model_reset();
        m_phase = P_IDLE; m_age = 0; m_div = 0; m_ns = 0; m_wup = 0;
        m_cnt = 0; m_en_q = 0; m_req = 0; m_ovr = 0;
    endtask

    // Advance one clock using the inputs currently presented to the DUT.
    task automatic model_step();
        bit start;
        bit full;
        bit tk;
        start = en && !m_en_q;
        case (m_phase)
            P_IDLE: if (start) begin
                m_div = int'(div); m_ns = int'(ns); m_wup = int'(wup);
                m_cnt = 0; m_ovr = 0; m_age = 0;
                m_phase = (m_wup == 0) ? P_RUN : P_WUP;
            end
            P_WUP: begin
                if (!en) m_phase = P_IDLE;
                else if (m_age + 1 == m_wup) begin m_phase = P_RUN; m_age = 0; end
                else m_age++;
            end
            P_RUN: begin
                if (!en) begin
                    m_phase = P_IDLE; m_req = 0;
                end else begin
                    full = (m_ns != 0) && (m_cnt == m_ns);
                    tk   = (m_age % (m_div + 1)) == m_div;
                    m_age++;
                    if (full) begin
                        if (!m_req) m_phase = P_DONE;
                        else if (ack) m_req = 0;
                    end else if (tk) begin
                        if (!m_req || ack) begin
                            m_req = 1;
                            if (m_cnt != 65535) m_cnt++;
                        end else m_ovr = 1;
                    end else if (ack) m_req = 0;
                end
            end
            default: if (!en) m_phase = P_IDLE;
        endcase
        m_en_q = en;
    endtask

    function automatic state_e exp_state(input int p);
        case (p)
            P_WUP:   return ST_WARMUP;
            P_RUN:   return ST_RUN;
            P_DONE:  return ST_DONE;
            default: return ST_IDLE;
        endcase
    endfunction

    task automatic check_all(input string tag);
        chk({tag, "_req"},   32'(req_o),  32'(m_req));
        chk({tag, "_busy"},  32'(busy_o), 32'((m_phase == P_WUP) || (m_phase == P_RUN)));
        chk({tag, "_done"},  32'(done_o), 32'(m_phase == P_DONE));
        chk({tag, "_ovr"},   32'(ovr_o),  32'(m_ovr));
        chk({tag, "_cnt"},   32'(cnt_o),  32'(m_cnt));
        chk({tag, "_state"}, 32'(dbg_o),  32'(exp_state(m_phase)));
    endtask

    // ---------------- ack driver ----------------
    int ack_mode = 0;   // 0: ack after ack_d cycles of req, 1: ack = req, 2: random
    int ack_d    = 1;
    int hi_cnt   = 0;

    task automatic drive_ack();
        if (req_o) hi_cnt++; else hi_cnt = 0;
        case (ack_mode)
            0:       ack = req_o && (hi_cnt == ack_d);
            1:       ack = req_o;
            default: ack = req_o ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
        endcase
    endtask

    // One clock: model and DUT advance together, then compare mid-cycle.
    task automatic cycle(input string tag);
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_all(tag);
        drive_ack();
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int k;
        int first_exp;
        bit prev_req;
        int rise_q[$];

        // Reset with en held high and scenario-1 config applied.
        model_reset();
        en = 1'b1; div = 8'd3; wup = 4'd2; ns = 16'd4; ack_mode = 0; ack_d = 1;
        repeat (3) @(negedge clk);
        check_all("reset");
        rst_n = 1'b1;

        // Scenario 1: warm-up 2, div 3, burst 4, prompt ack.
        cycle("s1");
        chk("s1_busy_clk1", 32'(busy_o), 32'd1);
        first_exp = 1 + 2 + 3 + 1;
        prev_req = 1'b0;
        k = 2;
        while (k <= 200 && !done_o) begin
            cycle("s1");
            if (req_o && !prev_req) rise_q.push_back(k);
            prev_req = req_o;
            k++;
        end
        chk("s1_done", 32'(done_o), 32'd1);
        chk("s1_nreq", 32'(rise_q.size()), 32'd4);
        if (rise_q.size() > 0) chk("s1_first_req", 32'(rise_q[0]), 32'(first_exp));
        for (int i = 1; i < rise_q.size(); i++) chk("s1_spacing", 32'(rise_q[i] - rise_q[i-1]), 32'd4);
        chk("s1_cnt", 32'(cnt_o), 32'd4);
        chk("s1_ovr", 32'(ovr_o), 32'd0);

        // DONE holds while en stays high.
        repeat (3) cycle("s1_hold");

        // Scenario 2: first ack withheld ~10 cycles -> overrun.
        en = 1'b0;
        cycle("s2_idle");
        ack_d = 11;
        en = 1'b1;
        k = 0;
        while (k < 300 && !done_o) begin
            cycle("s2");
            if (ack) ack_d = 1;
            k++;
        end
        chk("s2_done", 32'(done_o), 32'd1);
        chk("s2_ovr", 32'(ovr_o), 32'd1);
        chk("s2_cnt", 32'(cnt_o), 32'd4);

        // Scenario 3: div 0, continuous, ack tied to req (tick+ack every cycle).
        en = 1'b0;
        cycle("s3_idle");
        ack_mode = 1; div = 8'd0; ns = 16'd0; wup = 4'd0;
        en = 1'b1;
        repeat (30) cycle("s3");
        chk("s3_cnt", 32'(cnt_o), 32'd29);
        chk("s3_req", 32'(req_o), 32'd1);
        chk("s3_busy", 32'(busy_o), 32'd1);
        chk("s3_ovr", 32'(ovr_o), 32'd0);

        // Scenario 4: abort after 2 samples, then restart with warm-up.
        en = 1'b0;
        cycle("s4_idle");
        ack_mode = 0; ack_d = 1; div = 8'd3; wup = 4'd2; ns = 16'd0;
        en = 1'b1;
        k = 0;
        while (k < 100 && cnt_o != 16'd2) begin
            cycle("s4");
            k++;
        end
        chk("s4_reach2", 32'(cnt_o), 32'd2);
        en = 1'b0;
        cycle("s4_abort");
        chk("s4_abort_state", 32'(dbg_o), 32'(ST_IDLE));
        chk("s4_abort_req", 32'(req_o), 32'd0);
        chk("s4_abort_busy", 32'(busy_o), 32'd0);
        chk("s4_abort_cnt", 32'(cnt_o), 32'd2);
        en = 1'b1;
        cycle("s4_restart");
        chk("s4_restart_cnt", 32'(cnt_o), 32'd0);
        chk("s4_restart_state", 32'(dbg_o), 32'(ST_WARMUP));
        repeat (12) cycle("s4_run");

        // Scenario 5: async reset during RUN with req high.
        en = 1'b0;
        cycle("s5_idle");
        ack_mode = 2; div = 8'd0; wup = 4'd0; ns = 16'd0;
        en = 1'b1;
        k = 0;
        while (k < 50 && !(req_o && cnt_o > 16'd2)) begin
            cycle("s5");
            k++;
        end
        chk("s5_req_before", 32'(req_o), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("s5_arst_req",  32'(req_o),  32'd0);
        chk("s5_arst_busy", 32'(busy_o), 32'd0);
        chk("s5_arst_cnt",  32'(cnt_o),  32'd0);
        chk("s5_arst_ovr",  32'(ovr_o),  32'd0);
        chk("s5_arst_state", 32'(dbg_o), 32'(ST_IDLE));
        model_reset();
        en = 1'b0;
        ack = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cycle("s5_post");

        // Scenario 6: randomized enables, config churn and ack timing.
        ack_mode = 2;
        for (int i = 0; i < 600; i++) begin
            div = DIV_W'($urandom_range(0, 3));
            ns  = CNT_W'($urandom_range(0, 5));
            wup = WUP_W'($urandom_range(0, 3));
            if ($urandom_range(0, 24) == 0) en = !en;
            cycle("rnd");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/samplerenctrl.md
Name: samplerenctrl

Overview:
- Sampler-domain controller that sequences the sampler. It consumes the synchronized sampler clock-enable level and produces a paced sample-request stream with a req/ack handshake.
- Each run has a programmable warm-up delay, a programmable sample rate (divider) and a programmable burst length.
- Reports busy, done, overrun and sample count to the sampler top.
- Sits between the clock-enable synchronizer and the sampler datapath, entirely in the clk_sampler domain.

Parameters:
- DIV_W, 8, width of the sample-period divider config.
- CNT_W, 16, width of the burst-length config and the sample counter.
- WUP_W, 4, width of the warm-up cycle-count config.

Ports:
- clk_sampler  input  1  sampler clock.
- rst_sampler_n_sync  input  1  asynchronous active-low reset, already synchronized to clk_sampler.
- clksamplerensync_samplerenctrl_clksampleren_r_sync  input  1  synchronized enable level (en).
- samplertop_samplerenctrl_div  input  DIV_W  sample period minus 1, in clocks.
- samplertop_samplerenctrl_nsamples  input  CNT_W  burst length; 0 = continuous.
- samplertop_samplerenctrl_warmup  input  WUP_W  warm-up cycles before the first tick.
- sampler_samplerenctrl_ack  input  1  single-cycle acknowledge of req.
- samplerenctrl_sampler_req  output  1  sample request level.
- samplerenctrl_samplertop_busy  output  1  high in WARMUP or RUN.
- samplerenctrl_samplertop_done  output  1  burst complete.
- samplerenctrl_samplertop_overrun  output  1  sticky: a tick was dropped.
- samplerenctrl_samplertop_cnt  output  CNT_W  samples issued in the current run.

Behaviour:
- Reset (async, low): state = IDLE; en_q = 0; req, busy, done, overrun = 0; cnt = 0; divider and warm-up counters = 0. All outputs are registered.
- Start: a start occurs when en = 1 and en_q = 0. Because en_q resets to 0, en held high through reset starts a run on the first clock after reset.
- IDLE:
  - On start, latch div, nsamples and warmup into shadow registers; clear cnt and overrun.
  - If warmup = 0, go to RUN; otherwise go to WARMUP.
  - Config inputs are ignored at all times other than start.
- WARMUP:
  - Lasts exactly warmup cycles, then goes to RUN.
  - en = 0 returns to IDLE.
- RUN:
  - The divider counter clears on RUN entry and increments every cycle.
  - A tick occurs when the counter equals div_sh; the counter then wraps to 0. Ticks therefore occur every div_sh+1 cycles; the first tick is on RUN cycle index div_sh (0-based).
  - On a tick with room (req = 0, or req = 1 with ack in the same cycle):
    - req is 1 the next cycle;
    - cnt increments;
    - in that ack-coincident case, req stays high and no overrun is flagged.
  - On a tick with req = 1 and no ack: the tick is dropped, overrun is set (sticky), and cnt is unchanged.
  - ack with req = 1 and no tick: req = 0 the next cycle. ack with req = 0 is ignored.
  - If nsamples_sh != 0 and cnt = nsamples_sh: further ticks are suppressed and do not flag overrun. Go to DONE once req = 0.
  - cnt saturates at all-ones in continuous mode; it does not wrap.
- DONE:
  - done = 1 and busy = 0.
  - Stays in DONE until en = 0, then goes to IDLE with done = 0.
  - A new run needs a new rising edge of en.
- Abort: en = 0 in WARMUP or RUN goes to IDLE the next cycle and clears req. Any outstanding request is abandoned. cnt and overrun hold their values until the next start.
- Simultaneous abort and tick: abort wins; cnt is not incremented.
- Reset mid-run: all state returns to reset values immediately, asynchronously.

Decomposition:
- Shared sync package/include gets the state encoding constants (IDLE, WARMUP, RUN, DONE; 2 bits) and default widths.
- One natural sub-module, samplerenctrl_divider: a loadable modulo counter with a tick output, reused for warm-up with a terminal-count compare.

Test Plan:
- Reset with en = 1, div = 3, warmup = 2, nsamples = 4, ack 1 cycle after each req: busy on clock 1; first req 2+3+1 cycles after start; 4 reqs spaced 4 cycles; done = 1; cnt = 4; overrun = 0.
- Same config with ack withheld for 10 cycles after the first req: overrun = 1; cnt stays 1 until ack; done only after the 4th ack.
- div = 0, nsamples = 0, ack tied to req: a tick every cycle; req held continuously; cnt increments every cycle; no overrun; busy stays high.
- en dropped mid-RUN after 2 samples: next cycle state = IDLE, req = 0, busy = 0, cnt = 2; re-raise en: cnt clears and run restarts with warm-up.
- Tick and ack in the same cycle with req high: req stays 1, cnt increments, overrun stays 0.
- Assert reset during RUN with req = 1: req, busy, cnt and overrun go to 0 asynchronously, before the next clock edge.
